decode_issue_stage: RTL and testbench

//  RV32I decode/issue stage between instruction fetch and the register file / execute stage.

---
 rtl/decode_issue_if.sv | 34 +++
 rtl/decode_issue_stage.sv | 201 ++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Fetch-side and issue-side handshake bundle for the decode/issue stage.
// master: fetch + EX environment view; slave: the decode/issue stage view.
// Both channels use valid/ready; payload is qualified by the matching valid.
interface decode_issue_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  logic            id_valid;
  logic            ex_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [4:0]      id_rd;
  logic            id_w_en;
  logic            id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, id_valid, id_pc, id_imm, id_opcode, id_funct3,
           id_funct7, id_rd, id_w_en, id_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, id_valid, id_pc, id_imm, id_opcode, id_funct3,
           id_funct7, id_rd, id_w_en, id_illegal
  );
endinterface

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage with a RAW/WAW scoreboard; optional stall counter via DECODE_STALL_CNT_EN.
// Latency: 2 cycles fetch-to-EX minimum (capture into decode slot, then issue slot).
// Backpressure: if_ready drops while the decode slot is held by a hazard or a stalled issue slot.
module decode_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  decode_issue_if.slave bus,
  input  logic        flush,
  output logic [4:0]  r1,
  output logic [4:0]  r2,
  output logic        r_en,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall_haz
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {EMPTY, FULL, STALL_HAZ, STALL_BP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_valid;
  logic [NREG-1:0] sb_pending, sb_nxt, busy_vec;
  logic            use_rs1, use_rs2, wr_op, illegal, wen;
  logic [XLEN-1:0] imm;
  logic            hazard, issue, fire_in;

  wire [6:0] opc = dec_instr[6:0];
  wire [4:0] rd  = dec_instr[11:7];
  wire [4:0] rs1 = dec_instr[19:15];
  wire [4:0] rs2 = dec_instr[24:20];

  assign dec_valid = (state != EMPTY);

  // Classify the decode-slot opcode: source use, destination write, immediate format.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_op   = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        wr_op = 1'b1;
        imm   = {{(XLEN-31){dec_instr[31]}}, dec_instr[30:12], 12'b0};
      end
      OPC_JAL: begin
        wr_op = 1'b1;
        imm   = {{(XLEN-20){dec_instr[31]}}, dec_instr[19:12], dec_instr[20],
                 dec_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        use_rs1 = 1'b1;
        wr_op   = 1'b1;
        imm     = {{(XLEN-12){dec_instr[31]}}, dec_instr[31:20]};
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_op   = 1'b1;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{(XLEN-12){dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]};
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{(XLEN-12){dec_instr[31]}}, dec_instr[7], dec_instr[30:25],
                   dec_instr[11:8], 1'b0};
      end
      OPC_FENCE, OPC_SYSTEM: begin
        imm = {{(XLEN-12){dec_instr[31]}}, dec_instr[31:20]};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wen = wr_op && (rd != 5'd0);

  // Registers still owed a write: pending minus the one retiring now, plus the issue-slot writer.
  always_comb begin
    busy_vec = sb_pending;
    if (wb_valid) busy_vec[wb_rd] = 1'b0;
    if (bus.id_valid && bus.id_w_en) busy_vec[bus.id_rd] = 1'b1;
    busy_vec[0] = 1'b0;
  end

  assign hazard = (use_rs1 && busy_vec[rs1]) || (use_rs2 && busy_vec[rs2]) ||
                  (wen && busy_vec[rd]);
  assign issue  = dec_valid && !hazard && !flush && (!bus.id_valid || bus.ex_ready);
  assign bus.if_ready = !dec_valid || issue;
  assign fire_in = bus.if_valid && bus.if_ready && !flush;
  assign stall_haz = dec_valid && hazard;
  assign r_en = issue;
  assign r1 = rs1;
  assign r2 = rs2;

  // Decode-slot state: flush wins, a freed slot refills from fetch, otherwise record why it waits.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (!dec_valid || issue) begin
      state_nxt = bus.if_valid ? FULL : EMPTY;
    end else if (hazard) begin
      state_nxt = STALL_HAZ;
    end else begin
      state_nxt = STALL_BP;
    end
  end

  // Decode-slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Capture the fetched instruction into the decode slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_instr <= '0;
      dec_pc    <= '0;
    end else if (fire_in) begin
      dec_instr <= bus.if_instr;
      dec_pc    <= bus.if_pc;
    end
  end

  // Issue slot: load on issue, drop when EX takes it without a replacement, squash on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.id_valid   <= 1'b0;
      bus.id_pc      <= '0;
      bus.id_imm     <= '0;
      bus.id_opcode  <= '0;
      bus.id_funct3  <= '0;
      bus.id_funct7  <= '0;
      bus.id_rd      <= '0;
      bus.id_w_en    <= 1'b0;
      bus.id_illegal <= 1'b0;
    end else if (flush) begin
      bus.id_valid <= 1'b0;
    end else if (issue) begin
      bus.id_valid   <= 1'b1;
      bus.id_pc      <= dec_pc;
      bus.id_imm     <= imm;
      bus.id_opcode  <= opc;
      bus.id_funct3  <= dec_instr[14:12];
      bus.id_funct7  <= dec_instr[31:25];
      bus.id_rd      <= rd;
      bus.id_w_en    <= wen;
      bus.id_illegal <= illegal;
    end else if (bus.id_valid && bus.ex_ready) begin
      bus.id_valid <= 1'b0;
    end
  end

  // Scoreboard update: writeback clears, handoff to EX sets (set wins); a squashed packet never sets.
  always_comb begin
    sb_nxt = sb_pending;
    if (wb_valid) sb_nxt[wb_rd] = 1'b0;
    if (bus.id_valid && bus.ex_ready && bus.id_w_en && !flush) sb_nxt[bus.id_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_pending <= '0;
    else        sb_pending <= sb_nxt;
  end

`ifdef DECODE_STALL_CNT_EN
  // Count cycles where a held instruction could not issue for a reason other than flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (dec_valid && !issue && !flush) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized bench for decode_issue_stage: stimulus pushes expected decoded packets,
// a negedge monitor tracks the two pipeline slots and in-flight writes at instruction level
// and compares handshake, hazard, read-port and packet outputs every cycle.
module tb_decode_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [4:0]  r1, r2;
  logic        r_en, stall_haz;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  decode_issue_if bus ();

  decode_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .r1        (r1),
    .r2        (r2),
    .r_en      (r_en),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .stall_haz (stall_haz)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        w_en;
    logic        ill;
  } pkt_t;

  typedef struct packed {
    pkt_t       p;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       issued;
  } ent_t;

  int checks = 0;
  int failures = 0;

  ent_t       acc_q[$];   // expected packets of accepted fetches, not yet seen by the monitor
  ent_t       mq[$];      // instructions inside the stage, oldest first
  logic [4:0] ret_q[$];   // registers handed to EX, awaiting writeback
  logic [31:0] inflight = '0;
  logic        mon_en = 1'b0;
  logic        wb_en = 1'b1;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference decode straight from the ISA field definitions.
  function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    logic wr;
    byte  fmt;
    e = '0;
    e.p.pc = pc; e.p.opc = ins[6:0]; e.p.f3 = ins[14:12]; e.p.f7 = ins[31:25];
    e.p.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    wr = 1'b0; fmt = "N";
    case (ins[6:0])
      7'h37, 7'h17: begin fmt = "U"; wr = 1'b1; end
      7'h6F:        begin fmt = "J"; wr = 1'b1; end
      7'h67, 7'h03, 7'h13: begin fmt = "I"; wr = 1'b1; e.use1 = 1'b1; end
      7'h33:        begin wr = 1'b1; e.use1 = 1'b1; e.use2 = 1'b1; end
      7'h23:        begin fmt = "S"; e.use1 = 1'b1; e.use2 = 1'b1; end
      7'h63:        begin fmt = "B"; e.use1 = 1'b1; e.use2 = 1'b1; end
      7'h0F, 7'h73: fmt = "I";
      default:      e.p.ill = 1'b1;
    endcase
    case (fmt)
      "I": e.p.imm = {20'b0, ins[31:20]} - (ins[31] ? 32'd4096 : 32'd0);
      "S": e.p.imm = {20'b0, ins[31:25], ins[11:7]} - (ins[31] ? 32'd4096 : 32'd0);
      "B": e.p.imm = {19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}
                     - (ins[31] ? 32'd8192 : 32'd0);
      "U": e.p.imm = ins & 32'hFFFF_F000;
      "J": e.p.imm = {11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}
                     - (ins[31] ? 32'h0020_0000 : 32'd0);
      default: e.p.imm = 32'd0;
    endcase
    e.p.w_en = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    ins = $urandom;
    case ($urandom_range(0, 12))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
      4: op = 7'h03;  5: op = 7'h13;  6: op = 7'h33;  7: op = 7'h23;
      8: op = 7'h63;  9: op = 7'h0F; 10: op = 7'h73; 11: op = 7'h7F;
      default: op = 7'($urandom);
    endcase
    ins[6:0]   = op;
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  // One cycle of stimulus; records an accepted fetch as an expected packet.
  task automatic step(input logic v, input logic [31:0] ins, input logic er,
                      input logic fl, output logic acc);
    @(posedge clk);
    #1;
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc_ctr;
    bus.ex_ready = er; flush = fl;
    if (wb_en && ret_q.size() > 0 && $urandom_range(0, 2) == 0) begin
      wb_valid = 1'b1; wb_rd = ret_q.pop_front();
    end else begin
      wb_valid = 1'b0; wb_rd = 5'($urandom_range(0, 31));
    end
    #1;
    acc = v && bus.if_ready && !fl;
    if (acc) begin
      acc_q.push_back(ref_dec(ins, pc_ctr));
      pc_ctr += 32'd4;
    end
  endtask

  function automatic logic busy(input logic [4:0] x, input logic hid, input pkt_t idp);
    if (x == 5'd0) return 1'b0;
    return (inflight[x] && !(wb_valid && wb_rd == x)) || (hid && idp.w_en && idp.rd == x);
  endfunction

  logic m_hid, m_hdec, m_haz, m_ren, m_pop;
  int   m_di;
  ent_t m_d, m_e;
  pkt_t m_idp;

  // Monitor: compare this cycle's outputs against the instruction-level model, then advance it.
  always @(negedge clk) begin
    if (mon_en) begin
      m_hid  = (mq.size() > 0) && mq[0].issued;
      m_di   = m_hid ? 1 : 0;
      m_hdec = (mq.size() > m_di);
      m_d    = m_hdec ? mq[m_di] : '0;
      m_idp  = m_hid ? mq[0].p : '0;
      m_haz  = m_hdec && ((m_d.use1 && busy(m_d.rs1, m_hid, m_idp)) ||
                          (m_d.use2 && busy(m_d.rs2, m_hid, m_idp)) ||
                          (m_d.p.w_en && busy(m_d.p.rd, m_hid, m_idp)));
      m_ren  = m_hdec && !m_haz && !flush && (!m_hid || bus.ex_ready);

      check("id_valid", {127'b0, bus.id_valid}, {127'b0, m_hid});
      if (m_hid)
        check("id_packet", {40'b0, bus.id_pc, bus.id_imm, bus.id_opcode, bus.id_funct3,
                            bus.id_funct7, bus.id_rd, bus.id_w_en, bus.id_illegal},
              {40'b0, m_idp});
      check("stall_haz", {127'b0, stall_haz}, {127'b0, m_haz});
      check("r_en", {127'b0, r_en}, {127'b0, m_ren});
      check("if_ready", {127'b0, bus.if_ready}, {127'b0, !m_hdec || m_ren});
      if (m_hdec) check("r1_r2", {118'b0, r1, r2}, {118'b0, m_d.rs1, m_d.rs2});

      if (wb_valid) inflight[wb_rd] = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        m_pop = m_hid && bus.ex_ready;
        if (m_pop) begin
          m_e = mq.pop_front();
          if (m_e.p.w_en) begin
            inflight[m_e.p.rd] = 1'b1;
            ret_q.push_back(m_e.p.rd);
          end
        end
        if (m_ren) begin
          m_e = mq[m_pop ? m_di - 1 : m_di];
          m_e.issued = 1'b1;
          mq[m_pop ? m_di - 1 : m_di] = m_e;
        end
      end
      if (acc_q.size() > 0) mq.push_back(acc_q.pop_front());
    end
  end

  logic [31:0] dir [5];
  logic [31:0] cur;
  logic        acc, got;
  int          dptr;

  initial begin
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
    dir[0] = 32'h0050_0093;  // addi x1,x0,5
    dir[1] = 32'h0010_8133;  // add  x2,x1,x1
    dir[2] = 32'h0020_A423;  // sw   x2,8(x1)
    dir[3] = 32'h0000_006F;  // jal  x0,0
    dir[4] = 32'h0000_007F;  // illegal opcode

    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {40'b0, bus.id_valid, bus.id_pc, bus.id_imm, bus.id_opcode,
                            bus.id_funct3, bus.id_funct7, bus.id_rd, bus.id_w_en,
                            bus.id_illegal, r1, r2, r_en, stall_haz}, 128'd0);
    check("reset_if_ready", {127'b0, bus.if_ready}, 128'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed opening instructions, then random traffic with backpressure, flush and writeback.
    dptr = 0; cur = dir[0];
    for (int c = 0; c < 2500; c++) begin
      step((dptr < 5) ? 1'b1 : ($urandom_range(0, 9) < 7), cur,
           $urandom_range(0, 9) < 7, (c > 20) && ($urandom_range(0, 39) == 0), acc);
      if (acc) begin
        dptr++;
        cur = (dptr < 5) ? dir[dptr] : rand_instr();
      end
    end

    // Drain every in-flight instruction and outstanding writeback.
    for (int c = 0; c < 80; c++) step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    wb_en = 1'b0;

    // Producer then dependent consumer with writeback withheld: the consumer must stall.
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) step(1'b1, 32'h0050_0093, 1'b1, 1'b0, got);
    check("addi_accept", {127'b0, got}, 128'd1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) step(1'b1, 32'h0010_8133, 1'b1, 1'b0, got);
    check("add_accept", {127'b0, got}, 128'd1);
    for (int c = 0; c < 3; c++) step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    check("raw_stall_haz", {127'b0, stall_haz}, 128'd1);
    for (int c = 0; c < 3; c++) step(1'b1, 32'h0000_0013, 1'b0, 1'b0, acc);
    check("stalled_if_ready", {127'b0, bus.if_ready}, 128'd0);

    // Asynchronous reset in the middle of the stall.
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {40'b0, bus.id_valid, bus.id_pc, bus.id_imm, bus.id_opcode,
                                   bus.id_funct3, bus.id_funct7, bus.id_rd, bus.id_w_en,
                                   bus.id_illegal, r1, r2, r_en, stall_haz}, 128'd0);
    mq.delete(); acc_q.delete(); ret_q.delete(); inflight = '0;
    bus.if_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Scoreboard is clear after reset: the consumer issues without any writeback.
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) step(1'b1, 32'h0010_8133, 1'b1, 1'b0, got);
    check("post_reset_accept", {127'b0, got}, 128'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    check("post_reset_issue", {127'b0, r_en}, 128'd1);
    for (int c = 0; c < 5; c++) step(1'b0, 32'd0, 1'b1, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
